// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock valid/ready stream FIFO with occupancy reporting,
// programmable almost-full/almost-empty flags, a peak-level monitor and a
// synchronous flush.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   flush             synchronous discard of all stored entries
//   s_valid/s_ready   producer handshake, s_data payload
//   m_valid/m_ready   consumer handshake, m_data head word
//   level             stored entries (0..DEPTH)
//   almost_full       level >= AF_THRESH
//   almost_empty      level <= AE_THRESH
//   peak_level        maximum level since the last reset or flush
module sync_fifo_prog #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = 3,
    parameter int unsigned AE_THRESH = 1,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned LW       = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [LW-1:0]     level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [LW-1:0]     peak_level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_d;
    logic [LW-1:0]     peak_q;
    logic [LW-1:0]     peak_d;
    logic              push;
    logic              pop;

    // Handshake qualifiers decoded from registers only (no m_ready -> s_ready path)
    assign s_ready = ~reset & ~flush & (level_q != LW'(DEPTH));
    assign m_valid = ~reset & ~flush & (level_q != LW'(0));
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_data  = mem[rd_ptr];

    // Reported occupancy reads as empty while reset is held
    assign level        = reset ? LW'(0) : level_q;
    assign peak_level   = reset ? LW'(0) : peak_q;
    assign almost_full  = (level >= LW'(AF_THRESH));
    assign almost_empty = (level <= LW'(AE_THRESH));

    // Next occupancy and running maximum
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        peak_d = (level_d > peak_q) ? level_d : peak_q;
    end

    // Pointer, level and peak registers; reset and flush both clear them
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            peak_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_d;
            peak_q  <= peak_d;
        end
    end

    // Storage array, contents deliberately left intact on reset/flush
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog (DATA_W=32, DEPTH=4, AF=3, AE=1).
module tb_sync_fifo_prog;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 3;

    logic          clk = 1'b0;
    logic          reset, flush, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic [LW-1:0] level, peak_level;
    logic          almost_full, almost_empty;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_W(DW), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
        .peak_level(peak_level)
    );

    typedef struct {
        logic          rst, fl, sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          sr, mv, md_chk;
        logic [DW-1:0] md;
        logic [LW-1:0] lvl;
        logic          af, ae;
        logic [LW-1:0] pk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, fl, sv, input int sd, input logic mr,
                       input logic sr, mv, md_chk, input int md, input int lvl,
                       input logic af, ae, input int pk);
        vec_t v;
        v.rst = rst; v.fl = fl; v.sv = sv; v.sd = DW'(sd); v.mr = mr;
        v.sr = sr; v.mv = mv; v.md_chk = md_chk; v.md = DW'(md);
        v.lvl = LW'(lvl); v.af = af; v.ae = ae; v.pk = LW'(pk);
        vecs.push_back(v);
    endtask

    // One comparison: all outputs against expected values
    task automatic compare(input string name, input logic sr, mv, md_chk,
                           input logic [DW-1:0] md, input logic [LW-1:0] lvl,
                           input logic af, ae, input logic [LW-1:0] pk);
        bit bad = 0;
        n_vec++;
        if (s_ready !== sr)      begin bad = 1; $display("FAIL %s s_ready got %b want %b", name, s_ready, sr); end
        if (m_valid !== mv)      begin bad = 1; $display("FAIL %s m_valid got %b want %b", name, m_valid, mv); end
        if (md_chk && m_data !== md) begin bad = 1; $display("FAIL %s m_data got %0h want %0h", name, m_data, md); end
        if (level !== lvl)       begin bad = 1; $display("FAIL %s level got %0d want %0d", name, level, lvl); end
        if (almost_full !== af)  begin bad = 1; $display("FAIL %s almost_full got %b want %b", name, almost_full, af); end
        if (almost_empty !== ae) begin bad = 1; $display("FAIL %s almost_empty got %b want %b", name, almost_empty, ae); end
        if (peak_level !== pk)   begin bad = 1; $display("FAIL %s peak_level got %0d want %0d", name, peak_level, pk); end
        if (bad) n_bad++;
    endtask

    // Behavioural reference: a queue of words plus a running maximum
    logic [DW-1:0] mq[$];
    int            m_peak = 0;
    logic          popped;
    logic [DW-1:0] pop_word;
    logic          last_push;

    task automatic step(input string name, input logic rst, fl, sv,
                        input logic [DW-1:0] sd, input logic mr);
        logic e_sr, e_mv;
        int   e_lvl;
        @(negedge clk);
        reset = rst; flush = fl; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        e_sr  = !rst && !fl && (mq.size() < 4);
        e_mv  = !rst && !fl && (mq.size() > 0);
        e_lvl = rst ? 0 : mq.size();
        compare(name, e_sr, e_mv, e_mv, (mq.size() > 0) ? mq[0] : '0, LW'(e_lvl),
                e_lvl >= 3, e_lvl <= 1, rst ? LW'(0) : LW'(m_peak));
        popped    = e_mv && mr;
        pop_word  = m_data;
        last_push = e_sr && sv;
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
            m_peak = 0;
        end else begin
            if (popped) void'(mq.pop_front());
            if (last_push) mq.push_back(sd);
            if (mq.size() > m_peak) m_peak = mq.size();
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

        // rst fl sv sd mr | sr mv chk md lvl af ae pk
        add(1,0,0,0,0,   0,0,0,0,   0,0,1,0);   // in reset
        add(0,0,1,0,0,   1,0,0,0,   0,0,1,0);   // fill 0..3
        add(0,0,1,1,0,   1,1,1,0,   1,0,1,1);
        add(0,0,1,2,0,   1,1,1,0,   2,0,0,2);
        add(0,0,1,3,0,   1,1,1,0,   3,1,0,3);
        add(0,0,0,0,0,   0,1,1,0,   4,1,0,4);   // full
        add(0,0,0,0,1,   0,1,1,0,   4,1,0,4);   // drain
        add(0,0,0,0,1,   1,1,1,1,   3,1,0,4);
        add(0,0,0,0,1,   1,1,1,2,   2,0,0,4);
        add(0,0,0,0,1,   1,1,1,3,   1,0,1,4);
        add(0,0,0,0,0,   1,0,0,0,   0,0,1,4);   // empty, peak held
        add(0,0,1,10,0,  1,0,0,0,   0,0,1,4);   // level 3 then flush
        add(0,0,1,11,0,  1,1,1,10,  1,0,1,4);
        add(0,0,1,12,0,  1,1,1,10,  2,0,0,4);
        add(0,1,1,13,1,  0,0,0,0,   3,1,0,4);   // flush cycle: no handshake
        add(0,0,0,0,0,   1,0,0,0,   0,0,1,0);
        add(0,0,1,20,0,  1,0,0,0,   0,0,1,0);   // level 2 then reset during push
        add(0,0,1,21,0,  1,1,1,20,  1,0,1,1);
        add(1,0,1,22,0,  0,0,0,0,   0,0,1,0);
        add(0,0,1,32'hA5,0, 1,0,0,0, 0,0,1,0);
        add(0,0,0,0,1,   1,1,1,32'hA5, 1,0,1,1);
        add(0,0,0,0,0,   1,0,0,0,   0,0,1,1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; flush = vecs[i].fl; s_valid = vecs[i].sv;
            s_data = vecs[i].sd; m_ready = vecs[i].mr;
            #1;
            compare($sformatf("vec%0d", i), vecs[i].sr, vecs[i].mv, vecs[i].md_chk,
                    vecs[i].md, vecs[i].lvl, vecs[i].af, vecs[i].ae, vecs[i].pk);
        end

        // Concurrent push/pop at level 2 across pointer wrap
        step("conc_rst", 1, 0, 0, '0, 0);
        step("conc_fill", 0, 0, 1, 32'd30, 0);
        step("conc_fill", 0, 0, 1, 32'd31, 0);
        for (int k = 0; k < 6; k++) begin
            step("conc", 0, 0, 1, DW'(32 + k), 1);
            n_vec++;
            if (!popped || pop_word !== DW'(30 + k) || level !== 3'd2) begin
                n_bad++;
                $display("FAIL conc_order k=%0d got word %0d level %0d want word %0d level 2",
                         k, pop_word, level, 30 + k);
            end
        end

        // Random traffic against the queue model
        begin
            int   next_word = 0;
            int   expect_out = 0;
            int   cycles = 0;
            logic pending = 1'b0;
            step("rnd_rst", 1, 0, 0, '0, 0);
            while (expect_out < 100 && cycles < 5000) begin
                if (!pending) pending = (next_word < 100) && ($urandom_range(1) == 1);
                step("rnd", 0, 0, pending, DW'(next_word), $urandom_range(1) == 1);
                if (last_push) begin
                    pending = 1'b0;
                    next_word++;
                end
                if (popped) begin
                    n_vec++;
                    if (pop_word !== DW'(expect_out)) begin
                        n_bad++;
                        $display("FAIL rnd_order got %0d want %0d", pop_word, expect_out);
                    end
                    expect_out++;
                end
                cycles++;
            end
            n_vec++;
            if (expect_out != 100) begin
                n_bad++;
                $display("FAIL rnd_timeout popped %0d want 100", expect_out);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
